// File: rtl/toy_pkg.sv
`default_nettype none
//==============================================================================
// toy_pkg : shared widths and types for the TOY fetch path          Rev 1.0
//==============================================================================
package toy_pkg;

  localparam int TOY_ADDR_W = 8;
  localparam int TOY_WORD_W = 16;

  typedef logic [TOY_ADDR_W-1:0] toy_addr_t;
  typedef logic [TOY_WORD_W-1:0] toy_word_t;

  typedef struct packed {
    toy_word_t inst;
    toy_addr_t pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    STOP = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/toy_fetch_q.sv
`default_nettype none
//==============================================================================
// toy_fetch_q : 2-entry FIFO of fetch entries with flush           Rev 1.0
//==============================================================================
module toy_fetch_q
  import toy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  fetch_ent_t push_ent_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output fetch_ent_t head_o,
  output logic [1:0] count_o
);

  fetch_ent_t ent0_q, ent0_d;
  fetch_ent_t ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic       do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d  = push_ent_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            ent1_d  = push_ent_i;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            ent0_d = push_ent_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_ent_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/toy_fetch.sv
`default_nettype none
//==============================================================================
// toy_fetch : TOY instruction fetch, 2-deep return queue, redirect. Rev 1.0
// Optional same-cycle return bypass when TOY_FETCH_BYPASS_EN is defined.
//==============================================================================
module toy_fetch
  import toy_pkg::*;
#(
  parameter toy_addr_t START_PC  = 8'h10,
  parameter int        INIT_WAIT = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             redir_val_i,
  input  logic [7:0]       redir_pc_i,
  output logic             mem_val_o,
  output logic [7:0]       mem_addr_o,
  input  logic [15:0]      mem_rdata_i,
  output logic             inst_val_o,
  output logic [15:0]      inst_o,
  output logic [7:0]       inst_pc_o,
  input  logic             inst_rdy_i,
  output logic             busy_o
);

  localparam int               CNT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_WAIT - 1);

  fetch_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  toy_addr_t        pc_q;
  toy_addr_t        tag_q;
  logic             inflight_q;

  fetch_ent_t       head;
  fetch_ent_t       ret_ent;
  logic [1:0]       q_count;
  logic             q_empty;
  logic             ret_ok;
  logic             byp;
  logic             pop;
  logic             q_push;
  logic             q_pop;
  logic [2:0]       occ;
  logic             room;

  assign q_empty = (q_count == 2'd0);
  // A return that arrives alongside a redirect belongs to the old path.
  assign ret_ok  = inflight_q && !redir_val_i;
  assign ret_ent = '{inst: mem_rdata_i, pc: tag_q};

`ifdef TOY_FETCH_BYPASS_EN
  assign byp = q_empty && ret_ok;
`else
  assign byp = 1'b0;
`endif

  assign inst_val_o = !redir_val_i && (!q_empty || byp);
  assign inst_o     = byp ? mem_rdata_i : head.inst;
  assign inst_pc_o  = byp ? tag_q       : head.pc;

  assign pop    = inst_val_o && inst_rdy_i;
  assign q_push = ret_ok && !(byp && pop);
  assign q_pop  = pop && !byp;

  assign occ  = {1'b0, q_count} + {2'b00, inflight_q};
  assign room = occ < (3'd2 + {2'b00, pop});

  assign mem_val_o  = (state_q == RUN) && (redir_val_i || room);
  assign mem_addr_o = redir_val_i ? redir_pc_i : pc_q;
  assign busy_o     = (state_q == INIT);

  toy_fetch_q u_q (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (q_push),
    .push_ent_i (ret_ent),
    .pop_i      (q_pop),
    .flush_i    (redir_val_i),
    .head_o     (head),
    .count_o    (q_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      pc_q       <= START_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_val_o;
      if (mem_val_o) begin
        tag_q <= mem_addr_o;
        pc_q  <= mem_addr_o + 8'd1;
      end else if (redir_val_i) begin
        pc_q  <= redir_pc_i;
      end
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= run_i ? RUN : STOP;
          end
        end
        STOP:    if (run_i)  state_q <= RUN;
        RUN:     if (!run_i) state_q <= STOP;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule
`default_nettype wire
